// File: rtl/noc_pkg.sv
// ============================================================================
// Module      : noc_pkg
// Description : Flit format, field positions and parity helper shared by the
//               leaf packet transmitter and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int FLIT_W  = 9;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;

    localparam int DEST_HI = 8;
    localparam int DEST_LO = 5;
    localparam int PAY_HI  = 4;
    localparam int PAY_LO  = 1;
    localparam int PAR_BIT = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] payload;
        logic              parity;
    } flit_t;

    // Even parity: the XOR over the whole flit, parity bit included, is zero.
    function automatic logic calc_parity(input logic [ADDR_W-1:0] dest,
                                         input logic [DATA_W-1:0] payload);
        return ^{dest, payload};
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_sync_fifo.sv
// ============================================================================
// Module      : noc_sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers for full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign w_wr = wr_en_i & ~full_o;
    assign w_rd = rd_en_i & ~empty_o;

    // Storage is cleared on reset so the output reads zero until the first write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
                wr_ptr_q                   <= wr_ptr_q + 1'b1;
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/noc_packet_tx.sv
// ============================================================================
// Module      : noc_packet_tx
// Description : Leaf packet transmitter - builds parity-protected flits,
//               drops self-addressed requests, buffers and counts traffic.
//               Optional macro NOC_TX_ERR_INJECT_EN adds inject_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_packet_tx
    import noc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDRESS = 4'd0,
    parameter int                DEPTH   = 4,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_payload,
`ifdef NOC_TX_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    flit_t             w_flit;
    logic [FLIT_W-1:0] w_flit_bits;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  sent_cnt_q;
    logic [CNT_W-1:0]  sent_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;

    assign w_flit.dest    = in_dest;
    assign w_flit.payload = in_payload;
    assign w_flit.parity  = calc_parity(in_dest, in_payload);

    always_comb begin
        w_flit_bits = w_flit;
`ifdef NOC_TX_ERR_INJECT_EN
        w_flit_bits[PAR_BIT] = w_flit.parity ^ inject_err;
`endif
    end

    // Held low while reset is asserted so nothing is taken during reset.
    assign in_ready  = ~w_full & ~reset;
    assign out_valid = ~w_empty;

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & (in_dest == ADDRESS);
    assign w_push   = w_accept & ~w_drop;
    assign w_pop    = out_valid & out_ready;

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_push),
        .wr_data_i (w_flit_bits),
        .rd_en_i   (w_pop),
        .rd_data_o (out_flit),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    always_comb begin
        sent_cnt_d = sent_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (w_pop) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
        end
        if (w_drop) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            sent_cnt_q <= sent_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sent_cnt = sent_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_packet_tx.sv
// ============================================================================
// Module      : tb_noc_packet_tx
// Description : Directed self-checking bench for noc_packet_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_packet_tx;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dest;
    logic [3:0]  in_payload;
    logic        inject_err;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_flit;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;

    int n_pass;
    int n_total;

    noc_packet_tx #(
        .ADDRESS (4'd0),
        .DEPTH   (4),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_payload (in_payload),
`ifdef NOC_TX_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flit   (out_flit),
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] mkflit(input logic [3:0] d, input logic [3:0] p);
        return {d, p, ^{d, p}};
    endfunction

    logic [8:0] exp_q[$];
    logic [8:0] exp_f;
    int         accepted;
    int         popped;
    int         order_err;
    int         par_err;

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; in_valid = 1'b0; in_dest = '0; in_payload = '0;
        inject_err = 1'b0; out_ready = 1'b0;

        // Reset state
        step(); step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_flit",  {23'd0, out_flit},  32'd0);
        check("rst_sent",      {16'd0, sent_cnt},  32'd0);
        check("rst_drop",      {16'd0, drop_cnt},  32'd0);
        reset = 1'b0;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single request
        in_valid = 1'b1; in_dest = 4'h5; in_payload = 4'hA;
        step();
        in_valid = 1'b0;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_flit",  {23'd0, out_flit},  {23'd0, 9'b0101_1010_0});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_sent",  {16'd0, sent_cnt},  32'd1);
        check("single_empty", {31'd0, out_valid}, 32'd0);

        // Fill past capacity with the consumer stalled
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_dest = 4'(1 + i); in_payload = 4'(8 + i);
            if (in_ready) begin
                accepted++;
                exp_q.push_back(mkflit(4'(1 + i), 4'(8 + i)));
            end
            step();
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(accepted), 32'd4);
        check("fill_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_f = exp_q.pop_front();
            check("drain_valid", {31'd0, out_valid}, 32'd1);
            check("drain_flit",  {23'd0, out_flit},  {23'd0, exp_f});
            if (k == 0) check("drain_ready_before", {31'd0, in_ready}, 32'd0);
            step();
            if (k == 0) check("drain_ready_after",  {31'd0, in_ready}, 32'd1);
        end
        out_ready = 1'b0;
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_sent",  {16'd0, sent_cnt},  32'd5);

        // Self-addressed request is acknowledged and dropped
        in_valid = 1'b1; in_dest = 4'h0; in_payload = 4'h3;
        check("drop_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("drop_cnt",   {16'd0, drop_cnt},  32'd1);
        check("drop_valid", {31'd0, out_valid}, 32'd0);
        check("drop_sent",  {16'd0, sent_cnt},  32'd5);

        // Streaming: 64 cycles of continuous traffic
        popped = 0; order_err = 0; par_err = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1; in_dest = 4'(1 + (i % 15)); in_payload = 4'(i);
            if (out_valid) begin
                exp_f = exp_q.pop_front();
                if (out_flit !== exp_f) order_err++;
                if (^out_flit !== 1'b0) par_err++;
                popped++;
            end
            if (in_ready) exp_q.push_back(mkflit(4'(1 + (i % 15)), 4'(i)));
            step();
        end
        in_valid = 1'b0;
        check("stream_throughput", 32'(popped), 32'd63);
        if (out_valid) begin
            exp_f = exp_q.pop_front();
            if (out_flit !== exp_f) order_err++;
            if (^out_flit !== 1'b0) par_err++;
        end
        step();
        out_ready = 1'b0;
        check("stream_order",  32'(order_err), 32'd0);
        check("stream_parity", 32'(par_err),   32'd0);
        check("stream_sent",   {16'd0, sent_cnt},  32'd69);
        check("stream_empty",  {31'd0, out_valid}, 32'd0);

        // Reset with three flits buffered
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_dest = 4'(2 + i); in_payload = 4'(i);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sent",  {16'd0, sent_cnt},  32'd0);
        check("mid_rst_drop",  {16'd0, drop_cnt},  32'd0);
        check("mid_rst_ready", {31'd0, in_ready},  32'd0);
        reset = 1'b0;
        step();
        check("after_rst_valid", {31'd0, out_valid}, 32'd0);
        check("after_rst_ready", {31'd0, in_ready},  32'd1);
        check("after_rst_flit",  {23'd0, out_flit},  32'd0);

`ifdef NOC_TX_ERR_INJECT_EN
        // Parity inversion on request
        in_valid = 1'b1; in_dest = 4'h3; in_payload = 4'h1; inject_err = 1'b1;
        step();
        in_valid = 1'b0; inject_err = 1'b0;
        check("inject_flit", {23'd0, out_flit}, {23'd0, 9'b0011_0001_0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
